// File: rtl/layer_if_pkg.sv
// Shared layer-boundary definitions: activation widths, vector sizes,
// the skid-buffer state encoding and the profiling counter width.
package layer_if_pkg;

  localparam int ACT_BITS   = 2;
  localparam int L0_NEURONS = 100;
  localparam int L1_NEURONS = 64;
  localparam int L1_FANIN   = 3;

  localparam int L0_VEC_W = ACT_BITS * L0_NEURONS;
  localparam int L1_IN_W  = ACT_BITS * L1_FANIN;
  localparam int L1_VEC_W = ACT_BITS * L1_NEURONS;

  localparam int               CNT_W   = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// Increment-enable counter that holds at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/layer0_to_layer1_skid_reg.sv
// Registered two-entry skid buffer between the layer-0 and layer-1 neuron
// arrays, with flush and saturating traffic/stall profiling counters.
module layer0_to_layer1_skid_reg #(
  parameter int ACT_BITS = layer_if_pkg::ACT_BITS,
  parameter int NUM_ACT  = layer_if_pkg::L0_NEURONS,
  parameter int CNT_W    = layer_if_pkg::CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [ACT_BITS*NUM_ACT-1:0] s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [ACT_BITS*NUM_ACT-1:0] m_data,
  output logic [CNT_W-1:0]            in_cnt,
  output logic [CNT_W-1:0]            out_cnt,
  output logic [CNT_W-1:0]            stall_cnt
);

  import layer_if_pkg::*;

  localparam int VEC_W = ACT_BITS * NUM_ACT;

  skid_state_t      state;
  logic [VEC_W-1:0] main_q;
  logic [VEC_W-1:0] skid_q;

  logic in_fire;
  logic out_fire;
  logic stall;

  assign in_fire  = s_valid && s_ready;
  assign out_fire = m_valid && m_ready;
  assign stall    = m_valid && !m_ready;
  assign m_data   = main_q;

  // m_valid and s_ready are registered alongside the state so neither port
  // sees a combinational path from the opposite side of the boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      s_ready <= 1'b0;
      main_q  <= '0;
    end else if (flush) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      s_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          s_ready <= 1'b1;
          if (in_fire) begin
            main_q  <= s_data;
            m_valid <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= s_data;
          end else if (in_fire) begin
            s_ready <= 1'b0;
            state   <= TWO;
          end else if (out_fire) begin
            m_valid <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_q  <= skid_q;
            s_ready <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          m_valid <= 1'b0;
          s_ready <= 1'b1;
          state   <= EMPTY;
        end
      endcase
    end
  end

  // NOTE: skid_q has no reset; its contents are only ever consumed from
  // state TWO, which cannot be reached without loading it first.
  always_ff @(posedge clk) begin
    if (!rst && !flush && (state == ONE) && in_fire && !out_fire) begin
      skid_q <= s_data;
    end
  end

  sat_counter #(.W(CNT_W)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_fire),
    .count (in_cnt)
  );

  sat_counter #(.W(CNT_W)) u_out_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_fire),
    .count (out_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (stall_cnt)
  );

endmodule

// File: doc/layer0_to_layer1_skid_reg.md
Name: layer0_to_layer1_skid_reg

Overview:
- Registered, elastic boundary between the layer-0 neuron array and the layer-1 neuron array.
- Captures the flattened 2-bit activation vector from layer 0 and presents it to the layer-1 LUT neurons. Each layer-1 neuron indexes a 3-input, 6-bit slice of this vector.
- Uses a 2-entry skid buffer with valid/ready on both sides, so backpressure from later stages never corrupts or drops a sample.
- Adds flush and saturating per-boundary traffic/stall counters for throughput profiling.

Parameters:
- ACT_BITS, 2, bits per activation (neuron output width).
- NUM_ACT, 100, number of layer-0 neurons whose outputs cross this boundary.
- CNT_W, 32, width of the profiling counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of both buffer entries; counters are kept.
- s_valid  in  1  layer-0 vector valid.
- s_ready  out  1  boundary can accept a vector.
- s_data  in  ACT_BITS*NUM_ACT  layer-0 flattened activations; neuron k occupies bits [k*ACT_BITS +: ACT_BITS].
- m_valid  out  1  vector available to layer 1.
- m_ready  in  1  layer-1 side accepts.
- m_data  out  ACT_BITS*NUM_ACT  vector presented to layer-1 neurons.
- in_cnt  out  CNT_W  accepted input transfers.
- out_cnt  out  CNT_W  completed output transfers.
- stall_cnt  out  CNT_W  cycles with m_valid=1 and m_ready=0.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: m_valid=0, m_data=0, s_ready=0 while rst=1, s_ready=1 on the first cycle after rst deasserts, all counters 0.
- Transfer definitions: an input transfer is s_valid&&s_ready at a clk edge; an output transfer is m_valid&&m_ready at a clk edge.
- Storage:
  - main register drives m_data/m_valid directly (no combinational path from s_data to m_data).
  - skid register holds one extra vector.
- State machine:
  - EMPTY: main and skid empty; m_valid=0, s_ready=1.
    - Input transfer -> load main, go to ONE.
  - ONE: main full; m_valid=1, s_ready=1.
    - In and out together -> main reloads from s_data, stay in ONE.
    - In only -> skid loads, go to TWO.
    - Out only -> go to EMPTY.
  - TWO: main and skid full; m_valid=1, s_ready=0.
    - Out transfer -> main loads from skid, go to ONE.
- s_ready is a registered output, asserted exactly when the skid register is empty and rst=0.
- Latency: 1 cycle from input transfer to m_valid when EMPTY. Full throughput is 1 vector/cycle when m_ready is held high.
- Ordering is strictly FIFO. No vector is duplicated or dropped.
- m_data is held stable while m_valid=1 and m_ready=0.
- m_data after an output transfer that empties the block:
  - keeps its last value (not zeroed); layer-1 LUTs may evaluate it harmlessly.
  - only m_valid qualifies the data.
- flush=1 at a clk edge:
  - next state EMPTY, m_valid=0, s_ready=1.
  - an input or output handshake occurring in the same cycle is discarded; counters still count it, because the handshake did complete at the port.
- rst has priority over flush.
- rst mid-operation discards both entries and clears all counters.
- Counters:
  - each increments by 1 per qualifying event and saturates at 2^CNT_W-1 (no wrap).
  - flush does not clear them.
- s_data content is not checked. Any bit pattern is a legal activation vector.

Decomposition:
- Shared package (layer_if_pkg):
  - ACT_BITS, per-layer neuron counts, derived vector widths.
  - state enum {EMPTY, ONE, TWO}.
  - CNT_W and the saturating-max constant.
- One natural sub-module: sat_counter (width-parameterised increment-enable saturating counter), instantiated three times.
- Optional: the slice-gather wiring that feeds each layer-1 neuron's 6-bit input stays outside this block in the layer-1 wrapper.

Test Plan:
- Reset and single pass:
  - hold rst 3 cycles, release, m_ready=1.
  - send s_data=0x…0A5 for one cycle -> m_valid=1 next cycle with m_data=0x…0A5, then 0.
  - in_cnt=1, out_cnt=1, stall_cnt=0.
- Streaming:
  - 16 back-to-back vectors (s_data = index i) with m_ready=1 -> outputs 0..15 on consecutive cycles, s_ready never drops.
- Backpressure:
  - m_ready=0, send vectors 0x1, 0x2, 0x3 -> accept 1 and 2, s_ready=0 from the cycle after 2 is accepted; 3 is held off.
  - raise m_ready -> outputs in order 1, 2, 3; stall_cnt equals the number of m_valid&&!m_ready cycles.
- Random valid/ready:
  - 10k cycles, random s_valid and m_ready -> scoreboard confirms order and no loss or duplication.
  - m_data stays stable whenever stalled; in_cnt − out_cnt ∈ {0, 1, 2}.
- Flush:
  - with state TWO (vectors 0x7, 0x8 buffered), pulse flush -> m_valid=0 next cycle, s_ready=1.
  - the next input 0x9 emerges as the first output.
  - counters not cleared.
- Saturation and reset mid-op:
  - with CNT_W=4, stall 20 cycles -> stall_cnt=15.
  - assert rst while in TWO -> m_valid=0, counters=0, and no stale vector appears after release.
